// File: rtl/axi_m3_rd_firewall.sv
// Read-channel access firewall for AXI master 3.
// Legal AR requests (S1, S5, S6 windows) pass straight through to the NOC.
// Everything else is absorbed here and answered with a locally generated
// DECERR burst. The DECERR burst is held back until all earlier legal
// reads have returned, which keeps per-ID ordering intact.
module axi_m3_rd_firewall #(
  parameter logic [1:0]  MASTER_IDX      = 2'd3,
  parameter int          MAX_OUTSTANDING = 8,
  parameter logic [31:0] ERR_RDATA       = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [60:0] s_ar_pld,
  input  logic        s_ar_valid,
  output logic        s_ar_ready,
  output logic [40:0] s_r_pld,
  output logic        s_r_valid,
  input  logic        s_r_ready,
  output logic [60:0] m_ar_pld,
  output logic        m_ar_valid,
  input  logic        m_ar_ready,
  input  logic [40:0] m_r_pld,
  input  logic        m_r_valid,
  output logic        m_r_ready,
  output logic [15:0] err_count,
  output logic        err_pulse
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAIN    = 2'd1,
    ERR_DATA = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       id_q;
  logic [3:0]       len_q;
  logic [3:0]       beat;

  logic [31:0] ar_addr;
  logic [3:0]  ar_id;
  logic [3:0]  ar_len;
  logic        ar_legal;
  logic        cnt_full;
  logic        ar_hs;
  logic        err_hs;
  logic        m_ar_hs;
  logic        m_r_last_hs;
  logic        err_last;
  logic        err_r_hs;

  // Inclusive address window test.
  function automatic logic in_window(input logic [31:0] a,
                                     input logic [31:0] lo,
                                     input logic [31:0] hi);
    return (a >= lo) && (a <= hi);
  endfunction

  // Saturating 16-bit increment; the error counter never wraps.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign ar_addr = s_ar_pld[56:25];
  assign ar_id   = s_ar_pld[60:57];
  assign ar_len  = s_ar_pld[24:21];

  // Only the start address is checked; the burst end is deliberately ignored.
  assign ar_legal = in_window(ar_addr, 32'h0000_2000, 32'h0000_2FFF) ||
                    in_window(ar_addr, 32'h0000_A000, 32'h0000_AFFF) ||
                    in_window(ar_addr, 32'h0000_C000, 32'h0000_CFFF);

  assign cnt_full    = (cnt == CNT_MAX);
  assign ar_hs       = s_ar_valid && s_ar_ready;
  assign err_hs      = ar_hs && !ar_legal && (state == IDLE);
  assign m_ar_hs     = m_ar_valid && m_ar_ready;
  assign m_r_last_hs = m_r_valid && m_r_ready && m_r_pld[0];
  assign err_last    = (beat == len_q);
  assign err_r_hs    = (state == ERR_DATA) && s_r_ready;

  // Payload is forwarded unconditionally; m_ar_valid decides if it counts.
  assign m_ar_pld = s_ar_pld;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (err_hs) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // Wait for every earlier legal read to finish before answering.
        if (cnt == '0) begin
          state_nxt = ERR_DATA;
        end
      end
      ERR_DATA: begin
        if (err_r_hs && err_last) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs and R-channel mux; everything is held low in reset.
  always_comb begin
    s_ar_ready = 1'b0;
    m_ar_valid = 1'b0;
    s_r_valid  = m_r_valid;
    s_r_pld    = m_r_pld;
    m_r_ready  = s_r_ready;
    case (state)
      IDLE: begin
        if (!ar_legal) begin
          s_ar_ready = 1'b1;
        end else if (!cnt_full) begin
          s_ar_ready = m_ar_ready;
          m_ar_valid = s_ar_valid;
        end
      end
      ERR_DATA: begin
        s_r_valid = 1'b1;
        s_r_pld   = {MASTER_IDX, id_q, ERR_RDATA, 2'b11, err_last};
        m_r_ready = 1'b0;
      end
      default: begin
        s_ar_ready = 1'b0;
        m_ar_valid = 1'b0;
      end
    endcase
    if (rst) begin
      s_ar_ready = 1'b0;
      m_ar_valid = 1'b0;
      s_r_valid  = 1'b0;
      m_r_ready  = 1'b0;
    end
  end

  // Outstanding legal read counter; simultaneous inc/dec cancel, no underflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      case ({m_ar_hs, m_r_last_hs})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= (cnt == '0) ? cnt : cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Capture ID and length of the rejected request for the DECERR burst.
  always_ff @(posedge clk) begin
    if (err_hs) begin
      id_q  <= ar_id;
      len_q <= ar_len;
    end
  end

  // DECERR beat counter, cleared on the last beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat <= '0;
    end else if (err_r_hs) begin
      beat <= err_last ? 4'd0 : beat + 4'd1;
    end
  end

  // Rejection statistics: saturating count and a one-cycle pulse per reject.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= err_hs;
      if (err_hs) begin
        err_count <= sat_inc16(err_count);
      end
    end
  end

endmodule
